muldiv_arbiter: RTL

Arbiter and sequencer that shares one multi-cycle arithmetic unit (multiplier or divider, `ALU_OPCODE_WIDTH` opcode interface) between two execute-stage requesters. It accepts one operation at a time and drives the unit's opcode and operands. It waits for the unit to finish, then returns the tagged result to the requester that issued it, holding the result until that requester acknowledges it. It sits between the execute stages and the shared `alu_multiplier`/`alu_divider` instance.

---
 rtl/muldiv_arbiter_if.sv | 68 ++++++
 rtl/muldiv_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter_if.sv
// muldiv_arbiter_if: bundle of every signal between the muldiv arbiter, its two
// execute-stage requesters and the shared multi-cycle arithmetic unit.
//
// Signal groups:
//   requesters -> arbiter : req_valid, req_opcode0/1, req_src1_0/1, req_src2_0/1,
//                           req_insn_id0/1, resp_ready, flush
//   arbiter -> requesters : req_ready, resp_valid, resp_data, resp_insn_id, arb_busy
//   arbiter -> unit       : unit_opcode, unit_src1, unit_src2
//   unit -> arbiter       : unit_busy, unit_done, unit_result
//
// Modports:
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus unit), used by benches.
interface muldiv_arbiter_if #(
    parameter int unsigned ALU_OPCODE_WIDTH = 4
);
    logic [1:0]                  req_valid;
    logic [ALU_OPCODE_WIDTH-1:0] req_opcode0;
    logic [ALU_OPCODE_WIDTH-1:0] req_opcode1;
    logic [31:0]                 req_src1_0;
    logic [31:0]                 req_src2_0;
    logic [31:0]                 req_src1_1;
    logic [31:0]                 req_src2_1;
    logic [2:0]                  req_insn_id0;
    logic [2:0]                  req_insn_id1;
    logic [1:0]                  req_ready;

    logic [ALU_OPCODE_WIDTH-1:0] unit_opcode;
    logic [31:0]                 unit_src1;
    logic [31:0]                 unit_src2;
    logic                        unit_busy;
    logic                        unit_done;
    logic [31:0]                 unit_result;

    logic [1:0]                  resp_valid;
    logic [31:0]                 resp_data;
    logic [2:0]                  resp_insn_id;
    logic [1:0]                  resp_ready;

    logic                        flush;
    logic                        arb_busy;

    modport slave (
        input  req_valid, req_opcode0, req_opcode1,
        input  req_src1_0, req_src2_0, req_src1_1, req_src2_1,
        input  req_insn_id0, req_insn_id1,
        output req_ready,
        output unit_opcode, unit_src1, unit_src2,
        input  unit_busy, unit_done, unit_result,
        output resp_valid, resp_data, resp_insn_id,
        input  resp_ready,
        input  flush,
        output arb_busy
    );

    modport master (
        output req_valid, req_opcode0, req_opcode1,
        output req_src1_0, req_src2_0, req_src1_1, req_src2_1,
        output req_insn_id0, req_insn_id1,
        input  req_ready,
        input  unit_opcode, unit_src1, unit_src2,
        output unit_busy, unit_done, unit_result,
        input  resp_valid, resp_data, resp_insn_id,
        output resp_ready,
        output flush,
        input  arb_busy
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: shares one multi-cycle multiply/divide unit between two
// execute-stage requesters. One operation is in flight at a time: it is issued
// to the unit for exactly one cycle, the arbiter waits for the unit to finish,
// then holds the tagged result for the owning requester until it is acked.
// A flush abandons the in-flight operation; if the unit is still working the
// arbiter drains it (waits for done, discards the result) before re-arbitrating.
//
// Configuration macro:
//   MULDIV_ARB_RR_EN  defined   -> round-robin between tied requesters
//                     undefined -> fixed priority, requester 0 wins ties
//
// Ports:
//   CLK    in  clock, rising edge
//   RST_N  in  asynchronous active-low reset
//   bus    muldiv_arbiter_if.slave (requests, unit handshake, responses, flush,
//          arb_busy). req_ready is combinational; all other outputs registered.
module muldiv_arbiter #(
    parameter int unsigned                 NREQ             = 2,
    parameter int unsigned                 ALU_OPCODE_WIDTH = 4,
    parameter logic [ALU_OPCODE_WIDTH-1:0] ALU_NOP          = '0,
    parameter logic [2:0]                  ID_INVALID       = 3'b111
) (
    input logic             CLK,
    input logic             RST_N,
    muldiv_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } state_e;

    state_e                      state_q, state_d;
    logic [NREQ-1:0]             eligible;
    logic [NREQ-1:0]             grant;
    logic                        unit_fin;

    logic                        owner_q;
    logic [ALU_OPCODE_WIDTH-1:0] unit_opcode_q;
    logic [31:0]                 unit_src1_q;
    logic [31:0]                 unit_src2_q;
    logic [2:0]                  insn_id_q;
    logic [NREQ-1:0]             resp_valid_q;
    logic [31:0]                 resp_data_q;
    logic [2:0]                  resp_insn_id_q;

    // A NOP request is treated as if it were not requesting at all.
    assign eligible[0] = bus.req_valid[0] && (bus.req_opcode0 != ALU_NOP);
    assign eligible[1] = bus.req_valid[1] && (bus.req_opcode1 != ALU_NOP);

    assign unit_fin = bus.unit_done && !bus.unit_busy;

`ifdef MULDIV_ARB_RR_EN
    // Most recent grantee; reset to 1 so requester 0 wins the first tie.
    logic last_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q <= 1'b1;
        end else if (|grant) begin
            last_q <= grant[1];
        end
    end
`endif

    // Grants only from IDLE and never in a flush cycle.
    always_comb begin
        grant = '0;
        if (state_q == StIdle && !bus.flush) begin
`ifdef MULDIV_ARB_RR_EN
            if (eligible == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
`else
            if (eligible[0]) begin
                grant = 2'b01;
            end else if (eligible[1]) begin
                grant = 2'b10;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|grant) state_d = StIssue;
            end
            // The issue always completes; a flush here only diverts to DRAIN.
            StIssue: begin
                state_d = bus.flush ? StDrain : StWait;
            end
            // Flush coinciding with completion: the unit is already free, so the
            // result is dropped and there is nothing left to drain.
            StWait: begin
                if (unit_fin) begin
                    state_d = bus.flush ? StIdle : StResp;
                end else if (bus.flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                if (bus.flush || bus.resp_ready[owner_q]) state_d = StIdle;
            end
            StDrain: begin
                if (unit_fin) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= StIdle;
            owner_q        <= 1'b0;
            unit_opcode_q  <= ALU_NOP;
            unit_src1_q    <= '0;
            unit_src2_q    <= '0;
            insn_id_q      <= ID_INVALID;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            resp_insn_id_q <= ID_INVALID;
        end else begin
            state_q <= state_d;

            // Opcode is presented only during the single ISSUE cycle; operands
            // stay on the unit inputs until the next grant.
            if (|grant) begin
                owner_q <= grant[1];
                if (grant[1]) begin
                    unit_opcode_q <= bus.req_opcode1;
                    unit_src1_q   <= bus.req_src1_1;
                    unit_src2_q   <= bus.req_src2_1;
                    insn_id_q     <= bus.req_insn_id1;
                end else begin
                    unit_opcode_q <= bus.req_opcode0;
                    unit_src1_q   <= bus.req_src1_0;
                    unit_src2_q   <= bus.req_src2_0;
                    insn_id_q     <= bus.req_insn_id0;
                end
            end else if (state_q == StIssue) begin
                unit_opcode_q <= ALU_NOP;
            end

            if (state_q == StWait && state_d == StResp) begin
                resp_valid_q   <= owner_q ? 2'b10 : 2'b01;
                resp_data_q    <= bus.unit_result;
                resp_insn_id_q <= insn_id_q;
            end else if (state_q == StResp && state_d == StIdle) begin
                resp_valid_q   <= '0;
                resp_insn_id_q <= ID_INVALID;
            end
        end
    end

    assign bus.req_ready    = grant;
    assign bus.unit_opcode  = unit_opcode_q;
    assign bus.unit_src1    = unit_src1_q;
    assign bus.unit_src2    = unit_src2_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_insn_id = resp_insn_id_q;
    assign bus.arb_busy     = (state_q != StIdle);

endmodule
